// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART byte-command to register-bus bridge
module uart_cmd_bridge #(
  parameter int TO_CYCLES = 250000,
  parameter int BUS_TO    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  input  logic       txrdy,
  output logic       tx_vld,
  output logic [7:0] tx_data,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_wr,
  output logic       bus_rd,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_UNK = 8'h3F;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  // Timer widths are guarded so degenerate parameter values still give legal vectors.
  localparam int TO_W  = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam int BUS_W = (BUS_TO > 1) ? $clog2(BUS_TO + 1) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);
  localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP,
    S_WAIT_TX
  } state_t;

  state_t           r_state;
  logic             r_is_wr;
  logic [7:0]       r_resp;
  logic [TO_W-1:0]  r_timer;
  logic [BUS_W-1:0] r_bus_cnt;
  logic             r_tx_vld;
  logic [7:0]       r_tx_data;
  logic [7:0]       r_bus_addr;
  logic [7:0]       r_bus_wdata;
  logic             r_bus_wr;
  logic             r_bus_rd;
  logic [7:0]       r_drop_cnt;

  logic w_accepting;
  logic w_drop;
  logic w_timer_done;
  logic w_bus_done;

  // Only the command-collecting states take bytes; everything else discards them.
  assign w_accepting  = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
  assign w_drop       = rx_vld && !w_accepting;
  assign w_timer_done = (r_timer == TO_LAST);
  assign w_bus_done   = (r_bus_cnt == BUS_LAST);

  assign tx_vld    = r_tx_vld;
  assign tx_data   = r_tx_data;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wr    = r_bus_wr;
  assign bus_rd    = r_bus_rd;
  assign busy      = (r_state != S_IDLE);
  assign drop_cnt  = r_drop_cnt;

  // Command FSM with registered strobes, bus requests and response byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_resp      <= 8'h00;
      r_timer     <= '0;
      r_bus_cnt   <= '0;
      r_tx_vld    <= 1'b0;
      r_tx_data   <= 8'h00;
      r_bus_addr  <= 8'h00;
      r_bus_wdata <= 8'h00;
      r_bus_wr    <= 1'b0;
      r_bus_rd    <= 1'b0;
    end else begin
      r_tx_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer   <= '0;
          r_bus_cnt <= '0;
          if (rx_vld) begin
            if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
              r_is_wr <= (rx_data == OP_WR);
              r_state <= S_ADDR;
            end else begin
              r_resp  <= RSP_UNK;
              r_state <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_vld) begin
            r_bus_addr <= rx_data;
            r_timer    <= '0;
            if (r_is_wr) begin
              r_state <= S_WDATA;
            end else begin
              r_bus_rd  <= 1'b1;
              r_bus_cnt <= '0;
              r_state   <= S_BUS;
            end
          end else if (w_timer_done) begin
            // Partial command abandoned without any response byte.
            r_timer <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TO_W'(1);
          end
        end

        S_WDATA: begin
          if (rx_vld) begin
            r_bus_wdata <= rx_data;
            r_timer     <= '0;
            r_bus_wr    <= 1'b1;
            r_bus_cnt   <= '0;
            r_state     <= S_BUS;
          end else if (w_timer_done) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TO_W'(1);
          end
        end

        S_BUS: begin
          // An ack in the final timeout cycle still counts as a completed access.
          if (bus_ack) begin
            r_bus_wr  <= 1'b0;
            r_bus_rd  <= 1'b0;
            r_bus_cnt <= '0;
            r_resp    <= r_is_wr ? RSP_OK : bus_rdata;
            r_state   <= S_RESP;
          end else if (w_bus_done) begin
            r_bus_wr  <= 1'b0;
            r_bus_rd  <= 1'b0;
            r_bus_cnt <= '0;
            r_resp    <= RSP_ERR;
            r_state   <= S_RESP;
          end else begin
            r_bus_cnt <= r_bus_cnt + BUS_W'(1);
          end
        end

        S_RESP: begin
          if (txrdy) begin
            r_tx_vld  <= 1'b1;
            r_tx_data <= r_resp;
            r_state   <= S_WAIT_TX;
          end
        end

        S_WAIT_TX: begin
          // Wait for the transmitter to show it took the byte before allowing another strobe.
          if (!txrdy) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_bus_wr <= 1'b0;
          r_bus_rd <= 1'b0;
          r_timer  <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating count of bytes that arrived while no command could accept them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 8'h00;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - directed self-checking bench for uart_cmd_bridge
module tb_uart_cmd_bridge;

  localparam int TO = 64;
  localparam int BT = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       txrdy;
  logic       tx_vld;
  logic [7:0] tx_data;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       busy;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  int         tx_cnt;
  int         wr_cyc;
  int         rd_cyc;
  logic [7:0] last_tx;
  logic       any_both = 1'b0;
  logic       tx_hold = 1'b0;
  int         uart_busy = 0;

  uart_cmd_bridge #(.TO_CYCLES(TO), .BUS_TO(BT)) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data), .txrdy(txrdy),
    .tx_vld(tx_vld), .tx_data(tx_data), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for a few cycles after each strobe, or forced low.
  always @(negedge clk) begin
    if (rst) uart_busy = 0;
    else if (tx_vld) uart_busy = 4;
    else if (uart_busy > 0) uart_busy = uart_busy - 1;
    txrdy = !tx_hold && (uart_busy == 0);
  end

  // Activity monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_vld) begin
        tx_cnt  = tx_cnt + 1;
        last_tx = tx_data;
      end
      if (bus_wr) wr_cyc = wr_cyc + 1;
      if (bus_rd) rd_cyc = rd_cyc + 1;
      if (bus_wr && bus_rd) any_both = 1'b1;
    end
  end

  task automatic clr_mon;
    tx_cnt = 0; wr_cyc = 0; rd_cyc = 0; last_tx = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_vld = 1'b1; rx_data = b;
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_bus(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus_wr || bus_rd) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_tx(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; bus_ack = 1'b0; bus_rdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if ({tx_vld, bus_wr, bus_rd, busy} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {tx_vld, bus_wr, bus_rd, busy}); end
    checks++; if ({tx_data, bus_addr, bus_wdata, drop_cnt} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", {tx_data, bus_addr, bus_wdata, drop_cnt}); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    logic ok;
    clr_mon();
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    wait_bus(ok);
    checks++; if (!ok || bus_wr !== 1'b1) begin errors++; $display("FAIL write_req: got wr=%b expected 1", bus_wr); end
    checks++; if (bus_addr !== 8'h10 || bus_wdata !== 8'hA5) begin errors++; $display("FAIL write_addr_data: got %h/%h expected 10/a5", bus_addr, bus_wdata); end
    repeat (2) @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++; if (wr_cyc !== 3 || bus_wr !== 1'b0) begin errors++; $display("FAIL write_cycles: got %0d wr=%b expected 3 wr=0", wr_cyc, bus_wr); end
    wait_tx(1, ok);
    checks++; if (!ok || last_tx !== 8'h4B) begin errors++; $display("FAIL write_resp: got %h expected 4b", last_tx); end
    wait_idle(ok);
    repeat (5) @(negedge clk);
    checks++; if (!ok || tx_cnt !== 1 || rd_cyc !== 0) begin errors++; $display("FAIL write_single_tx: got tx=%0d rd=%0d expected 1/0", tx_cnt, rd_cyc); end
  endtask

  task automatic test_read;
    logic ok;
    clr_mon();
    send_byte(8'h52); send_byte(8'h22);
    wait_bus(ok);
    checks++; if (!ok || bus_rd !== 1'b1 || bus_addr !== 8'h22) begin errors++; $display("FAIL read_req: got rd=%b addr=%h expected 1/22", bus_rd, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 8'h3C;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 8'h00;
    wait_tx(1, ok);
    checks++; if (!ok || last_tx !== 8'h3C) begin errors++; $display("FAIL read_resp: got %h expected 3c", last_tx); end
    wait_idle(ok);
    checks++; if (!ok || rd_cyc !== 1 || wr_cyc !== 0) begin errors++; $display("FAIL read_cycles: got rd=%0d wr=%0d expected 1/0", rd_cyc, wr_cyc); end
  endtask

  task automatic test_unknown;
    logic ok;
    clr_mon();
    send_byte(8'h41);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unknown_busy: got %b expected 1", busy); end
    wait_tx(1, ok);
    checks++; if (!ok || last_tx !== 8'h3F) begin errors++; $display("FAIL unknown_resp: got %h expected 3f", last_tx); end
    wait_idle(ok);
    checks++; if (!ok || wr_cyc !== 0 || rd_cyc !== 0) begin errors++; $display("FAIL unknown_bus: got wr=%0d rd=%0d expected 0/0", wr_cyc, rd_cyc); end
  endtask

  task automatic test_inter_byte_timeout;
    clr_mon();
    send_byte(8'h57); send_byte(8'h10);
    repeat (TO - 1) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ibt_before: got busy=%b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ibt_after: got busy=%b expected 0", busy); end
    repeat (5) @(negedge clk);
    checks++; if (tx_cnt !== 0 || wr_cyc !== 0) begin errors++; $display("FAIL ibt_silent: got tx=%0d wr=%0d expected 0/0", tx_cnt, wr_cyc); end
  endtask

  task automatic test_bus_timeout;
    logic ok;
    clr_mon();
    send_byte(8'h52); send_byte(8'h33);
    wait_bus(ok);
    wait_tx(1, ok);
    checks++; if (!ok || last_tx !== 8'h45) begin errors++; $display("FAIL bus_to_resp: got %h expected 45", last_tx); end
    checks++; if (rd_cyc !== BT || bus_rd !== 1'b0) begin errors++; $display("FAIL bus_to_cycles: got %0d expected %0d", rd_cyc, BT); end
    wait_idle(ok);
  endtask

  task automatic test_ack_at_timeout;
    logic ok;
    clr_mon();
    send_byte(8'h52); send_byte(8'h44);
    wait_bus(ok);
    repeat (BT - 1) @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 8'h99;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 8'h00;
    wait_tx(1, ok);
    checks++; if (!ok || last_tx !== 8'h99) begin errors++; $display("FAIL ack_at_to_resp: got %h expected 99", last_tx); end
    checks++; if (rd_cyc !== BT) begin errors++; $display("FAIL ack_at_to_cycles: got %0d expected %0d", rd_cyc, BT); end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back;
    logic ok;
    logic [7:0] d0;
    clr_mon();
    d0 = drop_cnt;
    send_byte(8'h41);
    wait_tx(1, ok);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    rx_vld = 1'b1; rx_data = 8'h41;
    @(negedge clk);
    rx_vld = 1'b0;
    checks++; if (busy !== 1'b1 || drop_cnt !== d0) begin errors++; $display("FAIL b2b_accept: got busy=%b drop=%0d expected 1/%0d", busy, drop_cnt, d0); end
    wait_tx(2, ok);
    checks++; if (!ok || last_tx !== 8'h3F) begin errors++; $display("FAIL b2b_resp: got %h expected 3f", last_tx); end
    wait_idle(ok);
  endtask

  task automatic test_backpressure;
    logic ok;
    do_reset();
    clr_mon();
    tx_hold = 1'b1;
    send_byte(8'h41);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rx_vld = (i == 10) || (i == 40) || (i == 70);
      rx_data = 8'(i);
    end
    @(negedge clk);
    checks++; if (tx_cnt !== 0 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold: got tx=%0d busy=%b expected 0/1", tx_cnt, busy); end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL bp_drop: got %0d expected 3", drop_cnt); end
    tx_hold = 1'b0;
    wait_tx(1, ok);
    checks++; if (!ok || last_tx !== 8'h3F) begin errors++; $display("FAIL bp_resp: got %h expected 3f", last_tx); end
    wait_idle(ok);
  endtask

  task automatic test_drop_saturate;
    logic ok;
    do_reset();
    clr_mon();
    tx_hold = 1'b1;
    send_byte(8'h41);
    @(negedge clk);
    rx_vld = 1'b1; rx_data = 8'h55;
    repeat (254) @(negedge clk);
    rx_vld = 1'b0;
    checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d expected 254", drop_cnt); end
    rx_vld = 1'b1;
    @(negedge clk);
    rx_vld = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_255: got %0d expected 255", drop_cnt); end
    rx_vld = 1'b1;
    repeat (45) @(negedge clk);
    rx_vld = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
    tx_hold = 1'b0;
    wait_tx(1, ok);
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_bus;
    logic ok;
    do_reset();
    clr_mon();
    send_byte(8'h52); send_byte(8'h22);
    wait_bus(ok);
    checks++; if (!ok || bus_rd !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got rd=%b expected 1", bus_rd); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus_rd !== 1'b0 || busy !== 1'b0 || tx_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got rd=%b busy=%b tx=%b expected 0/0/0", bus_rd, busy, tx_vld); end
    checks++; if (bus_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_addr: got %h expected 00", bus_addr); end
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (tx_cnt !== 0 || busy !== 1'b0 || bus_rd !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet: got tx=%0d busy=%b rd=%b expected 0/0/0", tx_cnt, busy, bus_rd); end
    send_byte(8'h57);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_byte(8'h41);
    wait_tx(1, ok);
    checks++; if (!ok || last_tx !== 8'h3F || wr_cyc !== 0) begin errors++; $display("FAIL rst_restart: got %h wr=%0d expected 3f/0", last_tx, wr_cyc); end
    wait_idle(ok);
  endtask

  task automatic test_exclusive;
    checks++; if (any_both !== 1'b0) begin errors++; $display("FAIL wr_rd_exclusive: got %b expected 0", any_both); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_inter_byte_timeout();
    test_bus_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_backpressure();
    test_drop_saturate();
    test_reset_mid_bus();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameter TO_CYCLES, default 250000, inter-byte timeout in clk cycles (10 ms at 25 MHz).
REQ-002 Parameter BUS_TO, default 255, maximum clk cycles to wait for bus_ack.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_vld  input  1  one-cycle strobe from the UART receiver: rx_data holds a valid byte.
REQ-006 rx_data  input  8  received byte.
REQ-007 txrdy  input  1  UART transmitter idle; goes low the cycle after accepting tx_vld.
REQ-008 tx_vld  output  1  one-cycle strobe: tx_data is to be transmitted.
REQ-009 tx_data  output  8  response byte.
REQ-010 bus_addr  output  8  register address.
REQ-011 bus_wdata  output  8  write data.
REQ-012 bus_wr  output  1  write request, held until bus_ack or timeout.
REQ-013 bus_rd  output  1  read request, held until bus_ack or timeout.
REQ-014 bus_rdata  input  8  read data, valid in the cycle bus_ack=1.
REQ-015 bus_ack  input  1  one-cycle completion strobe from the register bus.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 drop_cnt  output  8  count of rx bytes discarded while not accepting, saturating at 255.

Function
REQ-018 Protocol: write = 0x57 ('W'), addr, data; read = 0x52 ('R'), addr; any other first byte is an unknown command.
REQ-019 States: IDLE, ADDR, WDATA, BUS, RESP, WAIT_TX.
REQ-020 IDLE + rx_vld: 0x57/0x52 -> latch opcode, go to ADDR; other value -> resp byte 0x3F ('?'), go to RESP.
REQ-021 ADDR + rx_vld: latch bus_addr; write -> WDATA; read -> BUS with bus_rd=1 in the next cycle.
REQ-022 WDATA + rx_vld: latch bus_wdata, go to BUS with bus_wr=1 in the next cycle.
REQ-023 Inter-byte timer: cleared on each rx_vld and runs only in ADDR and WDATA; reaching TO_CYCLES-1 returns to IDLE silently and discards the partial command.
REQ-024 BUS: the request stays high until bus_ack; on ack, a read responds with bus_rdata and a write responds with 0x4B ('K'); both clear the request in the same cycle and go to RESP.
REQ-025 BUS: if ack is absent for BUS_TO cycles, drop the request, respond 0x45 ('E'), and go to RESP; a bus_ack arriving in the timeout cycle takes priority.
REQ-026 RESP: when txrdy=1, assert tx_vld for exactly one cycle with tx_data = resp byte, then go to WAIT_TX; otherwise hold.
REQ-027 WAIT_TX: return to IDLE once txrdy is sampled low (transmitter accepted), so no second strobe can be issued before the UART updates txrdy.
REQ-028 Bytes arriving in BUS, RESP or WAIT_TX are discarded and increment drop_cnt, which saturates at 255 and never wraps.
REQ-029 tx_data and bus_addr/bus_wdata hold their last values when not strobed; bus_wr and bus_rd are never both high.
REQ-030 Latencies: IDLE-to-IDLE turnaround adds no extra cycles; a byte arriving in the same cycle the FSM enters IDLE is accepted.

Reset
REQ-031 While rst=1: state IDLE; tx_vld, bus_wr, bus_rd and busy are 0; tx_data, bus_addr, bus_wdata and drop_cnt are 0x00; all timers are 0.
REQ-032 rst mid-command or mid-bus-cycle: any outstanding request is abandoned immediately with no response byte; operation restarts in IDLE after rst deasserts.

Verification
REQ-033 Write: bytes 57,10,A5 (bus acks after 3 cycles) -> bus_wr with addr 0x10, data 0xA5; one tx_vld with 0x4B.
REQ-034 Read: bytes 52,22 (bus_rdata=0x3C with ack) -> bus_rd with addr 0x22; tx_vld with 0x3C.
REQ-035 Unknown: byte 0x41 -> tx_vld with 0x3F; no bus activity.
REQ-036 Timeouts: 57,10 then silence for TO_CYCLES -> back to IDLE with no tx; read with no ack -> request drops after BUS_TO cycles, tx 0x45.
REQ-037 Backpressure/drop: txrdy held low 100 cycles while 3 bytes arrive -> tx_vld waits for txrdy=1 and drop_cnt=3; 300 dropped bytes -> drop_cnt=255.
REQ-038 Reset: rst asserted with bus_rd pending -> bus_rd=0 and busy=0 immediately; no tx_vld afterward.
